reg_file_ckpt: RTL and testbench

- Parametrised successor to the rename register file.
- Holds architectural values plus a per-register ROB-tag table, and resolves source operands combinationally from the register file, the ROB or N CDB channels.
- Adds branch checkpoints: the tag table is snapshotted on branch rename and restored on misprediction, so a mispredict no longer wipes every pending tag.
- Sits between decode/issue and the ROB.

---
 rtl/reg_file_ckpt.sv | 187 ++++++++++++++++++
 tb/tb_reg_file_ckpt.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ckpt.sv
// Rename register file: architectural values, per-register ROB-tag table, operand
// bypass from ROB/CDB, and branch checkpoints of the tag table with nested-restore masks.
module reg_file_ckpt #(
  parameter int XLEN   = 32,
  parameter int REG_BW = 5,
  parameter int ROB_BW = 4,
  parameter int NCDB   = 2,
  parameter int NCKPT  = 4,
  parameter int CK_BW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic [REG_BW-1:0]      rs1,
  input  logic [REG_BW-1:0]      rs2,
  output logic [XLEN-1:0]        v1,
  output logic [XLEN-1:0]        v2,
  output logic [ROB_BW-1:0]      q1,
  output logic [ROB_BW-1:0]      q2,
  output logic [ROB_BW-1:0]      rob_q1,
  output logic [ROB_BW-1:0]      rob_q2,
  input  logic                   rob_rdy1,
  input  logic                   rob_rdy2,
  input  logic [XLEN-1:0]        rob_val1,
  input  logic [XLEN-1:0]        rob_val2,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*ROB_BW-1:0] cdb_tag,
  input  logic [NCDB*XLEN-1:0]   cdb_val,
  input  logic                   cm_valid,
  input  logic [REG_BW-1:0]      cm_rd,
  input  logic [ROB_BW-1:0]      cm_tag,
  input  logic [XLEN-1:0]        cm_val,
  input  logic                   rn_valid,
  input  logic [REG_BW-1:0]      rn_rd,
  input  logic [ROB_BW-1:0]      rn_tag,
  input  logic                   ck_alloc,
  output logic [CK_BW-1:0]       ck_id,
  output logic                   ck_full,
  input  logic                   ck_free_valid,
  input  logic [CK_BW-1:0]       ck_free_id,
  input  logic                   rs_valid,
  input  logic [CK_BW-1:0]       rs_id,
  input  logic                   flush
);

  localparam int NREG = 2 ** REG_BW;

  logic [XLEN-1:0]   reg_val  [NREG];
  logic [ROB_BW-1:0] tag      [NREG];
  logic [ROB_BW-1:0] snap     [NCKPT][NREG];
  logic [NCKPT-1:0]  ck_valid;
  logic [NCKPT-1:0]  young    [NCKPT];

  logic              cm_hit, rn_hit, do_alloc, do_free;
  logic [ROB_BW-1:0] tag_nx   [NREG];
  logic [ROB_BW-1:0] rs_tag   [NREG];
  logic [NCKPT-1:0]  valid_nx, rs_mask;
  logic [NCKPT-1:0]  young_nx [NCKPT];

  // Returns {value, tag}; the lowest-index matching CDB channel wins.
  function automatic logic [XLEN+ROB_BW-1:0] resolve(
    input logic [REG_BW-1:0]      rs,
    input logic [ROB_BW-1:0]      t,
    input logic [XLEN-1:0]        rv,
    input logic                   rrdy,
    input logic [XLEN-1:0]        rval,
    input logic [NCDB-1:0]        cv,
    input logic [NCDB*ROB_BW-1:0] ct,
    input logic [NCDB*XLEN-1:0]   cval
  );
    logic [XLEN-1:0] v;
    logic [ROB_BW-1:0] q;
    logic hit;
    logic [XLEN-1:0] hv;
    hit = 1'b0;
    hv  = '0;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (cv[k] && ct[k*ROB_BW +: ROB_BW] == t) begin
        hit = 1'b1;
        hv  = cval[k*XLEN +: XLEN];
      end
    end
    v = '0;
    q = '0;
    if (rs == '0)        v = '0;
    else if (t == '0)    v = rv;
    else if (rrdy)       v = rval;
    else if (hit)        v = hv;
    else                 q = t;
    return {v, q};
  endfunction

  assign {v1, q1} = resolve(rs1, tag[rs1], reg_val[rs1], rob_rdy1, rob_val1, cdb_valid, cdb_tag, cdb_val);
  assign {v2, q2} = resolve(rs2, tag[rs2], reg_val[rs2], rob_rdy2, rob_val2, cdb_valid, cdb_tag, cdb_val);
  assign rob_q1   = tag[rs1];
  assign rob_q2   = tag[rs2];

  assign cm_hit  = cm_valid && (cm_rd != '0);
  assign rn_hit  = rn_valid && (rn_rd != '0);
  assign ck_full = &ck_valid;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      tag_nx[i] = tag[i];
      rs_tag[i] = snap[rs_id][i];
      if (cm_hit && cm_rd == REG_BW'(i)) begin
        if (tag[i] == cm_tag)         tag_nx[i] = '0;
        if (snap[rs_id][i] == cm_tag) rs_tag[i] = '0;
      end
      if (rn_hit && rn_rd == REG_BW'(i)) tag_nx[i] = rn_tag;
    end
    tag_nx[0] = '0;
    rs_tag[0] = '0;
  end

  always_comb begin
    ck_id = '0;
    for (int k = NCKPT - 1; k >= 0; k--) begin
      if (!ck_valid[k]) ck_id = CK_BW'(k);
    end
  end

  // Checkpoint bookkeeping for a normal cycle; ck_id is taken before any free lands.
  always_comb begin
    valid_nx = ck_valid;
    young_nx = young;
    do_alloc = ck_alloc && !ck_full;
    do_free  = ck_free_valid && ck_valid[ck_free_id];
    if (do_alloc) begin
      for (int j = 0; j < NCKPT; j++) begin
        if (ck_valid[j]) young_nx[j][ck_id] = 1'b1;
      end
      young_nx[ck_id] = '0;
      valid_nx[ck_id] = 1'b1;
    end
    if (do_free) begin
      valid_nx[ck_free_id] = 1'b0;
      for (int j = 0; j < NCKPT; j++) young_nx[j][ck_free_id] = 1'b0;
    end
  end

  always_comb begin
    rs_mask        = young[rs_id];
    rs_mask[rs_id] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only; the combinational blocks above use blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: snapshots are reset too so a restore can never load unknown tags.
      for (int i = 0; i < NREG; i++) begin
        reg_val[i] <= '0;
        tag[i]     <= '0;
        for (int k = 0; k < NCKPT; k++) snap[k][i] <= '0;
      end
      ck_valid <= '0;
      for (int k = 0; k < NCKPT; k++) young[k] <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NREG; i++) tag[i] <= '0;
        ck_valid <= '0;
        for (int k = 0; k < NCKPT; k++) young[k] <= '0;
      end else begin
        if (cm_hit) reg_val[cm_rd] <= cm_val;
        for (int k = 0; k < NCKPT; k++) begin
          for (int i = 0; i < NREG; i++) begin
            if (cm_hit && cm_rd == REG_BW'(i) && snap[k][i] == cm_tag) snap[k][i] <= '0;
          end
        end
        if (rs_valid) begin
          for (int i = 0; i < NREG; i++) tag[i] <= rs_tag[i];
          ck_valid <= ck_valid & ~rs_mask;
          for (int k = 0; k < NCKPT; k++) young[k] <= young[k] & ~rs_mask;
        end else begin
          for (int i = 0; i < NREG; i++) tag[i] <= tag_nx[i];
          ck_valid <= valid_nx;
          for (int k = 0; k < NCKPT; k++) young[k] <= young_nx[k];
          if (do_alloc) begin
            for (int i = 0; i < NREG; i++) snap[ck_id][i] <= tag_nx[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_ckpt.sv
// Directed and random checks of reg_file_ckpt against a checkpoint model that tracks
// allocation order instead of young masks.
module tb_reg_file_ckpt;

  localparam int XLEN = 32, REG_BW = 5, ROB_BW = 4, NCDB = 2, NCKPT = 4, CK_BW = 2;
  localparam int NREG = 32;

  logic                   clk = 1'b0;
  logic                   rst, rdy;
  logic [REG_BW-1:0]      rs1, rs2;
  logic [XLEN-1:0]        v1, v2;
  logic [ROB_BW-1:0]      q1, q2, rob_q1, rob_q2;
  logic                   rob_rdy1, rob_rdy2;
  logic [XLEN-1:0]        rob_val1, rob_val2;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*ROB_BW-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_val;
  logic                   cm_valid, rn_valid, ck_alloc, ck_full, ck_free_valid, rs_valid, flush;
  logic [REG_BW-1:0]      cm_rd, rn_rd;
  logic [ROB_BW-1:0]      cm_tag, rn_tag;
  logic [XLEN-1:0]        cm_val;
  logic [CK_BW-1:0]       ck_id, ck_free_id, rs_id;

  reg_file_ckpt #(.XLEN(XLEN), .REG_BW(REG_BW), .ROB_BW(ROB_BW), .NCDB(NCDB),
                  .NCKPT(NCKPT), .CK_BW(CK_BW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs1(rs1), .rs2(rs2), .v1(v1), .v2(v2),
    .q1(q1), .q2(q2), .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_rdy1(rob_rdy1),
    .rob_rdy2(rob_rdy2), .rob_val1(rob_val1), .rob_val2(rob_val2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag), .ck_alloc(ck_alloc),
    .ck_id(ck_id), .ck_full(ck_full), .ck_free_valid(ck_free_valid),
    .ck_free_id(ck_free_id), .rs_valid(rs_valid), .rs_id(rs_id), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: values, live tags, snapshots, and allocation sequence per slot.
  logic [XLEN-1:0]   m_val  [NREG];
  logic [ROB_BW-1:0] m_tag  [NREG];
  logic [ROB_BW-1:0] m_snap [NCKPT][NREG];
  bit                m_valid[NCKPT];
  int                m_seq  [NCKPT];
  int                seq_ctr = 0;
  int                n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int m_lowest_free();
    for (int k = 0; k < NCKPT; k++) if (!m_valid[k]) return k;
    return -1;
  endfunction

  task automatic model_read(input logic [REG_BW-1:0] rs, input logic rr, input logic [XLEN-1:0] rv,
                            output logic [XLEN-1:0] v, output logic [ROB_BW-1:0] q);
    int ch;
    v = '0;
    q = '0;
    ch = -1;
    if (rs != '0) begin
      if (m_tag[rs] == '0) v = m_val[rs];
      else if (rr) v = rv;
      else begin
        for (int k = 0; k < NCDB; k++)
          if (ch < 0 && cdb_valid[k] && cdb_tag[k*ROB_BW +: ROB_BW] == m_tag[rs]) ch = k;
        if (ch >= 0) v = cdb_val[ch*XLEN +: XLEN];
        else q = m_tag[rs];
      end
    end
  endtask

  task automatic model_update();
    logic [ROB_BW-1:0] nt [NREG];
    int lf;
    bit cm_hit, do_free;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_tag[i] = '0; end
      for (int k = 0; k < NCKPT; k++) m_valid[k] = 0;
      return;
    end
    if (!rdy) return;
    lf = m_lowest_free();
    cm_hit = cm_valid && cm_rd != '0;
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_tag[i] = '0;
      for (int k = 0; k < NCKPT; k++) m_valid[k] = 0;
      return;
    end
    if (cm_hit) begin
      m_val[cm_rd] = cm_val;
      for (int k = 0; k < NCKPT; k++)
        if (m_valid[k] && m_snap[k][cm_rd] == cm_tag) m_snap[k][cm_rd] = '0;
    end
    if (rs_valid) begin
      for (int i = 0; i < NREG; i++) nt[i] = m_snap[rs_id][i];
      for (int k = 0; k < NCKPT; k++)
        if (m_valid[k] && m_seq[k] > m_seq[rs_id]) m_valid[k] = 0;
      m_valid[rs_id] = 0;
    end else begin
      for (int i = 0; i < NREG; i++) nt[i] = m_tag[i];
      if (cm_hit && nt[cm_rd] == cm_tag) nt[cm_rd] = '0;
      if (rn_valid && rn_rd != '0) nt[rn_rd] = rn_tag;
      do_free = ck_free_valid && m_valid[ck_free_id];
      if (ck_alloc && lf >= 0) begin
        for (int i = 0; i < NREG; i++) m_snap[lf][i] = nt[i];
        m_valid[lf] = 1;
        m_seq[lf] = seq_ctr++;
      end
      if (do_free) m_valid[ck_free_id] = 0;
    end
    for (int i = 0; i < NREG; i++) m_tag[i] = nt[i];
  endtask

  task automatic check_all();
    logic [XLEN-1:0] ev;
    logic [ROB_BW-1:0] eq;
    int lf;
    model_read(rs1, rob_rdy1, rob_val1, ev, eq);
    chk("v1", 64'(v1), 64'(ev));
    chk("q1", 64'(q1), 64'(eq));
    model_read(rs2, rob_rdy2, rob_val2, ev, eq);
    chk("v2", 64'(v2), 64'(ev));
    chk("q2", 64'(q2), 64'(eq));
    chk("rob_q1", 64'(rob_q1), 64'(m_tag[rs1]));
    chk("rob_q2", 64'(rob_q2), 64'(m_tag[rs2]));
    lf = m_lowest_free();
    chk("ck_full", 64'(ck_full), 64'(lf < 0));
    if (lf >= 0) chk("ck_id", 64'(ck_id), 64'(lf));
  endtask

  task automatic look();
    #1;
    check_all();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0;
    rob_rdy1 = 0; rob_rdy2 = 0; rob_val1 = '0; rob_val2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    cm_valid = 0; cm_rd = '0; cm_tag = '0; cm_val = '0;
    rn_valid = 0; rn_rd = '0; rn_tag = '0;
    ck_alloc = 0; ck_free_valid = 0; ck_free_id = '0; rs_valid = 0; rs_id = '0;
  endtask

  initial begin
    int k;
    idle();
    rs1 = 5'd5; rs2 = 5'd0;
    rst = 1;
    tick(); tick();
    idle();

    // Reset state
    look();
    chk("rst_ck_id", 64'(ck_id), 64'd0);
    chk("rst_ck_full", 64'(ck_full), 64'd0);
    chk("rst_q1", 64'(q1), 64'd0);
    chk("rst_v1", 64'(v1), 64'd0);

    // Commit x5 without a pending rename
    cm_valid = 1; cm_rd = 5'd5; cm_tag = 4'd3; cm_val = 32'h1234;
    tick(); idle();
    look();
    chk("commit_v1", 64'(v1), 64'h1234);
    chk("commit_q1", 64'(q1), 64'd0);

    // Rename x5 and resolve through ROB / CDB
    rn_valid = 1; rn_rd = 5'd5; rn_tag = 4'd2;
    tick(); idle();
    cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_val = {32'hAA, 32'h0};
    look();
    chk("cdb1_v1", 64'(v1), 64'hAA);
    chk("cdb1_q1", 64'(q1), 64'd0);
    tick();
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_val = {32'hAA, 32'h55};
    look();
    chk("cdb_prio_v1", 64'(v1), 64'h55);
    tick();
    cdb_tag = {4'd3, 4'd1};
    look();
    chk("nomatch_q1", 64'(q1), 64'd2);
    chk("nomatch_v1", 64'(v1), 64'd0);
    tick(); idle();
    rob_rdy1 = 1; rob_val1 = 32'hBEEF;
    look();
    chk("rob_v1", 64'(v1), 64'hBEEF);
    tick(); idle();

    // Nested checkpoints on x6 and restore of the older one
    rn_valid = 1; rn_rd = 5'd6; rn_tag = 4'd4; ck_alloc = 1;
    look();
    chk("ck0_id", 64'(ck_id), 64'd0);
    tick(); idle();
    rn_valid = 1; rn_rd = 5'd6; rn_tag = 4'd5; ck_alloc = 1;
    look();
    chk("ck1_id", 64'(ck_id), 64'd1);
    tick(); idle();
    rn_valid = 1; rn_rd = 5'd6; rn_tag = 4'd6;
    tick(); idle();
    rs_valid = 1; rs_id = 2'd0;
    tick(); idle();
    rs1 = 5'd6;
    look();
    chk("restore_q1", 64'(q1), 64'd4);
    chk("restore_ck_id", 64'(ck_id), 64'd0);
    chk("restore_ck_full", 64'(ck_full), 64'd0);
    tick(); idle();

    // Commit clears a snapshot entry; restore then shows the committed value
    rn_valid = 1; rn_rd = 5'd7; rn_tag = 4'd1; ck_alloc = 1;
    tick(); idle();
    cm_valid = 1; cm_rd = 5'd7; cm_tag = 4'd1; cm_val = 32'h77;
    tick(); idle();
    rn_valid = 1; rn_rd = 5'd7; rn_tag = 4'd9;
    tick(); idle();
    rs_valid = 1; rs_id = 2'd0;
    tick(); idle();
    rs1 = 5'd7;
    look();
    chk("snapclr_q1", 64'(q1), 64'd0);
    chk("snapclr_v1", 64'(v1), 64'h77);
    tick(); idle();

    // Fill all slots, overflow alloc, free, then nested restore
    for (int n = 0; n < NCKPT; n++) begin ck_alloc = 1; tick(); idle(); end
    look();
    chk("full", 64'(ck_full), 64'd1);
    ck_alloc = 1;
    tick(); idle();
    look();
    chk("full_hold", 64'(ck_full), 64'd1);
    ck_free_valid = 1; ck_free_id = 2'd2;
    tick(); idle();
    look();
    chk("free_full", 64'(ck_full), 64'd0);
    chk("free_id", 64'(ck_id), 64'd2);
    rs_valid = 1; rs_id = 2'd1;
    tick(); idle();
    look();
    chk("nested_id", 64'(ck_id), 64'd1);
    tick(); idle();

    // Same-cycle commit and rename of x9, then flush
    rn_valid = 1; rn_rd = 5'd9; rn_tag = 4'd3;
    tick(); idle();
    cm_valid = 1; cm_rd = 5'd9; cm_tag = 4'd3; cm_val = 32'h99;
    rn_valid = 1; rn_rd = 5'd9; rn_tag = 4'd7;
    tick(); idle();
    rs1 = 5'd9;
    look();
    chk("cmrn_q1", 64'(q1), 64'd7);
    tick(); idle();
    flush = 1;
    tick(); idle();
    rs1 = 5'd9; rs2 = 5'd5;
    look();
    chk("flush_q1", 64'(q1), 64'd0);
    chk("flush_v1", 64'(v1), 64'h99);
    chk("flush_q2", 64'(q2), 64'd0);
    chk("flush_v2", 64'(v2), 64'h1234);
    chk("flush_ck_id", 64'(ck_id), 64'd0);

    // rdy low holds all state
    rdy = 0; rn_valid = 1; rn_rd = 5'd9; rn_tag = 4'd5; ck_alloc = 1;
    tick(); idle();
    look();
    chk("hold_q1", 64'(q1), 64'd0);
    chk("hold_ck_id", 64'(ck_id), 64'd0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rob_rdy1 = ($urandom_range(0, 3) == 0);
      rob_rdy2 = ($urandom_range(0, 3) == 0);
      rob_val1 = $urandom;
      rob_val2 = $urandom;
      cdb_valid = 2'($urandom_range(0, 3));
      cdb_tag = {($urandom_range(0, 1) == 1) ? m_tag[rs1] : 4'($urandom), 4'($urandom_range(0, 15))};
      cdb_val = {$urandom, $urandom};
      cm_valid = ($urandom_range(0, 1) == 1);
      cm_rd = 5'($urandom_range(0, 7));
      cm_tag = ($urandom_range(0, 1) == 1) ? m_tag[cm_rd] : 4'($urandom_range(0, 15));
      cm_val = $urandom;
      rn_valid = ($urandom_range(0, 1) == 1);
      rn_rd = 5'($urandom_range(0, 7));
      rn_tag = 4'($urandom_range(1, 15));
      ck_alloc = ($urandom_range(0, 2) == 0);
      ck_free_valid = ($urandom_range(0, 3) == 0);
      ck_free_id = 2'($urandom_range(0, 3));
      k = $urandom_range(0, NCKPT - 1);
      rs_valid = ($urandom_range(0, 11) == 0) && m_valid[k];
      rs_id = 2'(k);
      look();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
